// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IEEE 1149.1 TAP state codes and the capture/update
// states that mark the start and end of a scan frame.
package jtag_pkg;

   typedef enum logic [3:0] {
      ST_EXIT2_DR         = 4'h0,
      ST_EXIT1_DR         = 4'h1,
      ST_SHIFT_DR         = 4'h2,
      ST_PAUSE_DR         = 4'h3,
      ST_SELECT_IR        = 4'h4,
      ST_UPDATE_DR        = 4'h5,
      ST_CAPTURE_DR       = 4'h6,
      ST_SELECT_DR        = 4'h7,
      ST_EXIT2_IR         = 4'h8,
      ST_EXIT1_IR         = 4'h9,
      ST_SHIFT_IR         = 4'hA,
      ST_PAUSE_IR         = 4'hB,
      ST_RUN_TEST_IDLE    = 4'hC,
      ST_UPDATE_IR        = 4'hD,
      ST_CAPTURE_IR       = 4'hE,
      ST_TEST_LOGIC_RESET = 4'hF
   } tap_state_e;

   localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
   localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;
   localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
   localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
   localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
   localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
   localparam logic [3:0] TAP_RESET      = 4'hF;

endpackage

// File: rtl/jtag_tap_mirror.sv
// Shadow copy of the device TAP controller, advanced by the same TMS the device sees.
// state               | meaning
// TEST_LOGIC_RESET    | TAP reset, held while tms=1 or trstn=0
// RUN_TEST_IDLE       | idle between scans
// SELECT_DR/IR        | choosing DR or IR path
// CAPTURE_DR/IR       | frame start
// SHIFT_DR/IR         | TDO bit valid each edge
// EXIT1/PAUSE/EXIT2   | exit or pause shifting, frame still open
// UPDATE_DR/IR        | frame end
module jtag_tap_mirror
   import jtag_pkg::*;
(
   input  logic       jtag_clk_i,
   input  logic       rst_n,
   input  logic       trstn,
   input  logic       tms,
   output logic [3:0] tap_state,
   output logic [3:0] next_state
);

   tap_state_e state_q;
   tap_state_e state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_TEST_LOGIC_RESET: state_d = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
         ST_RUN_TEST_IDLE:    state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
         ST_SELECT_DR:        state_d = tms ? ST_SELECT_IR        : ST_CAPTURE_DR;
         ST_CAPTURE_DR:       state_d = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
         ST_SHIFT_DR:         state_d = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
         ST_EXIT1_DR:         state_d = tms ? ST_UPDATE_DR        : ST_PAUSE_DR;
         ST_PAUSE_DR:         state_d = tms ? ST_EXIT2_DR         : ST_PAUSE_DR;
         ST_EXIT2_DR:         state_d = tms ? ST_UPDATE_DR        : ST_SHIFT_DR;
         ST_UPDATE_DR:        state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
         ST_SELECT_IR:        state_d = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
         ST_CAPTURE_IR:       state_d = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
         ST_SHIFT_IR:         state_d = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
         ST_EXIT1_IR:         state_d = tms ? ST_UPDATE_IR        : ST_PAUSE_IR;
         ST_PAUSE_IR:         state_d = tms ? ST_EXIT2_IR         : ST_PAUSE_IR;
         ST_EXIT2_IR:         state_d = tms ? ST_UPDATE_IR        : ST_SHIFT_IR;
         ST_UPDATE_IR:        state_d = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
         default:             state_d = ST_TEST_LOGIC_RESET;
      endcase
      // TAP reset wins over whatever TMS asks for
      if (!trstn) state_d = ST_TEST_LOGIC_RESET;
   end

   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= ST_TEST_LOGIC_RESET;
      else        state_q <= state_d;
   end

   assign tap_state  = state_q;
   assign next_state = state_d;

endmodule

// File: rtl/jtag_tdo_capture.sv
// Passive TDO monitor: deserialises each IR/DR scan and presents the frame with
// length, overflow flag and a masked compare against an expected value.
module jtag_tdo_capture
   import jtag_pkg::*;
#(
   parameter int MAX_BITS = 64,
   parameter int LEN_W    = 7
) (
   input  logic                jtag_clk_i,
   input  logic                rst_n,
   input  logic                trstn,
   input  logic                tms,
   input  logic                tdo,
   input  logic [MAX_BITS-1:0] exp_data,
   input  logic [MAX_BITS-1:0] exp_mask,
   output logic                cap_valid,
   output logic                cap_is_ir,
   output logic [LEN_W-1:0]    cap_len,
   output logic [MAX_BITS-1:0] cap_data,
   output logic                cap_match,
   output logic                cap_ovf,
   output logic [3:0]          tap_state,
   output logic [15:0]         frame_cnt
);

   localparam int               IDX_W   = $clog2(MAX_BITS);
   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BITS);

   logic [3:0]          next_state;
   logic [MAX_BITS-1:0] sr;
   logic [LEN_W-1:0]    bit_cnt;
   logic                ovf_r;
   logic                is_ir_r;
   logic                frame_seen;
   logic                in_shift;
   logic                frame_start;
   logic                frame_end;

   jtag_tap_mirror u_tap (
      .jtag_clk_i (jtag_clk_i),
      .rst_n      (rst_n),
      .trstn      (trstn),
      .tms        (tms),
      .tap_state  (tap_state),
      .next_state (next_state)
   );

   assign in_shift    = (tap_state == TAP_SHIFT_DR) || (tap_state == TAP_SHIFT_IR);
   assign frame_start = (next_state == TAP_CAPTURE_DR) || (next_state == TAP_CAPTURE_IR);
   assign frame_end   = (next_state == TAP_UPDATE_DR) || (next_state == TAP_UPDATE_IR);

   // An aborted frame needs no cleanup: the next CAPTURE clears it anyway
   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         sr      <= '0;
         bit_cnt <= '0;
         ovf_r   <= 1'b0;
         is_ir_r <= 1'b0;
      end else if (frame_start) begin
         sr      <= '0;
         bit_cnt <= '0;
         ovf_r   <= 1'b0;
         is_ir_r <= (next_state == TAP_CAPTURE_IR);
      end else if (in_shift) begin
         if (bit_cnt < MAX_CNT) begin
            sr[bit_cnt[IDX_W-1:0]] <= tdo;
            bit_cnt                <= bit_cnt + 1'b1;
         end else begin
            ovf_r <= 1'b1;
         end
      end
   end

   always_ff @(posedge jtag_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cap_valid  <= 1'b0;
         cap_is_ir  <= 1'b0;
         cap_len    <= '0;
         cap_data   <= '0;
         cap_ovf    <= 1'b0;
         frame_cnt  <= '0;
         frame_seen <= 1'b0;
      end else begin
         cap_valid <= frame_end;
         if (frame_end) begin
            cap_is_ir  <= is_ir_r;
            cap_len    <= bit_cnt;
            cap_data   <= sr;
            cap_ovf    <= ovf_r;
            frame_cnt  <= frame_cnt + 16'd1;
            frame_seen <= 1'b1;
         end
      end
   end

   // Live compare so the expected value presented during cap_valid is the one used
   assign cap_match = frame_seen && (((cap_data ^ exp_data) & exp_mask) == '0);

endmodule

// File: tb/tb_jtag_tdo_capture.sv
// Directed and randomized scans against jtag_tdo_capture, with expected frames
// derived from the bit stream each scan sends.
module tb_jtag_tdo_capture;

   logic        jtag_clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        trstn = 1'b1;
   logic        tms = 1'b1;
   logic        tdo = 1'b0;
   logic [63:0] exp_data = '0;
   logic [63:0] exp_mask = '0;
   logic        cap_valid;
   logic        cap_is_ir;
   logic [6:0]  cap_len;
   logic [63:0] cap_data;
   logic        cap_match;
   logic        cap_ovf;
   logic [3:0]  tap_state;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int valid_seen = 0;
   int exp_fc = 0;
   logic [63:0] last_data = '0;
   logic [6:0]  last_len = '0;
   logic        last_ir = 1'b0;
   logic        last_ovf = 1'b0;

   jtag_tdo_capture #(.MAX_BITS(64), .LEN_W(7)) dut (
      .jtag_clk_i (jtag_clk_i),
      .rst_n      (rst_n),
      .trstn      (trstn),
      .tms        (tms),
      .tdo        (tdo),
      .exp_data   (exp_data),
      .exp_mask   (exp_mask),
      .cap_valid  (cap_valid),
      .cap_is_ir  (cap_is_ir),
      .cap_len    (cap_len),
      .cap_data   (cap_data),
      .cap_match  (cap_match),
      .cap_ovf    (cap_ovf),
      .tap_state  (tap_state),
      .frame_cnt  (frame_cnt)
   );

   always #5 jtag_clk_i = ~jtag_clk_i;

   always @(negedge jtag_clk_i) if (cap_valid === 1'b1) valid_seen++;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tck(input logic t, input logic d);
      tms = t;
      tdo = d;
      @(posedge jtag_clk_i);
      #1;
   endtask

   function automatic logic [63:0] capvec(input logic [127:0] bits, input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n && i < 64; i++) v[i] = bits[i];
      return v;
   endfunction

   // Full scan from RUN_TEST_IDLE back to RUN_TEST_IDLE; pause_after=k pauses after bit k
   task automatic scan(input bit ir, input int n, input int pause_after,
                       input logic [127:0] bits, input logic [63:0] ed, input logic [63:0] em);
      logic [63:0] ecap;
      int base;
      ecap = capvec(bits, n);
      exp_data = ed;
      exp_mask = em;
      base = valid_seen;
      tck(1'b1, 1'b0);
      if (ir) tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      if (n == 0) tck(1'b1, 1'b0);
      else begin
         tck(1'b0, 1'b0);
         for (int i = 0; i < n; i++) begin
            if (i == n - 1) tck(1'b1, bits[i]);
            else if (i + 1 == pause_after) begin
               tck(1'b1, bits[i]);
               tck(1'b0, 1'b0);
               tck(1'b0, 1'b0);
               tck(1'b1, 1'b0);
               tck(1'b0, 1'b0);
            end else tck(1'b0, bits[i]);
         end
      end
      tck(1'b1, 1'b0);
      exp_fc = (exp_fc + 1) & 16'hFFFF;
      chk("valid_pulse", 64'(cap_valid), 64'(1));
      chk("update_state", 64'(tap_state), ir ? 64'hD : 64'h5);
      chk("is_ir", 64'(cap_is_ir), 64'(ir));
      chk("len", 64'(cap_len), 64'((n > 64) ? 64 : n));
      chk("data", cap_data, ecap);
      chk("ovf", 64'(cap_ovf), 64'(n > 64));
      chk("match", 64'(cap_match), 64'(((ecap ^ ed) & em) == 64'd0));
      chk("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
      tck(1'b0, 1'b0);
      chk("valid_clear", 64'(cap_valid), 64'(0));
      chk("one_pulse", 64'(valid_seen - base), 64'(1));
      last_data = ecap;
      last_len  = 7'((n > 64) ? 64 : n);
      last_ir   = ir;
      last_ovf  = (n > 64);
   endtask

   initial begin
      logic [127:0] bits;
      logic [63:0]  ev;
      int base, n, pa;
      bit ir;

      repeat (2) @(posedge jtag_clk_i);
      #1;
      chk("rst_state", 64'(tap_state), 64'hF);
      chk("rst_valid", 64'(cap_valid), 64'(0));
      chk("rst_fc", 64'(frame_cnt), 64'(0));
      chk("rst_match", 64'(cap_match), 64'(0));
      #2 rst_n = 1'b1;

      base = valid_seen;
      repeat (5) tck(1'b1, 1'b0);
      chk("tlr_hold", 64'(tap_state), 64'hF);
      chk("tlr_fc", 64'(frame_cnt), 64'(0));
      chk("tlr_no_valid", 64'(valid_seen - base), 64'(0));
      tck(1'b0, 1'b0);
      chk("rti", 64'(tap_state), 64'hC);

      // IR scan 1,0,1,0
      scan(1'b1, 4, 0, 128'h5, 64'h5, 64'hF);

      // 34-bit DR with exact and one-bit-off expectation
      bits = 128'h11111111;
      scan(1'b0, 34, 0, bits, 64'h11111111, '1);
      bits[7] = ~bits[7];
      scan(1'b0, 34, 0, bits, 64'h11111111, '1);

      // overflow then a short frame
      bits = '1;
      scan(1'b0, 70, 0, bits, '1, '1);
      bits = {$urandom, $urandom, $urandom, $urandom};
      scan(1'b0, 8, 0, bits, capvec(bits, 8), 64'hFF);

      // pause mid-frame
      bits = {$urandom, $urandom, $urandom, $urandom};
      scan(1'b0, 10, 5, bits, capvec(bits, 10), 64'h3FF);

      // zero-length frame
      scan(1'b0, 0, 0, '0, '0, '1);

      // randomized frames
      for (int k = 0; k < 8; k++) begin
         ir = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 80);
         pa = (n > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
         bits = {$urandom, $urandom, $urandom, $urandom};
         ev = capvec(bits, n);
         if ($urandom_range(0, 1) == 1) ev[$urandom_range(0, 63)] ^= 1'b1;
         scan(ir, n, pa, bits, ev, {$urandom, $urandom});
      end

      // trstn abort after 20 DR bits
      base = valid_seen;
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      tck(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) tck(1'b0, 1'($urandom));
      trstn = 1'b0;
      tck(1'b0, 1'b0);
      chk("abort_state", 64'(tap_state), 64'hF);
      trstn = 1'b1;
      tck(1'b0, 1'b0);
      chk("abort_no_valid", 64'(valid_seen - base), 64'(0));
      chk("abort_len", 64'(cap_len), 64'(last_len));
      chk("abort_data", cap_data, last_data);
      chk("abort_ir", 64'(cap_is_ir), 64'(last_ir));
      chk("abort_ovf", 64'(cap_ovf), 64'(last_ovf));
      chk("abort_fc", 64'(frame_cnt), 64'(exp_fc));

      // async reset mid-shift
      tck(1'b1, 1'b0);
      tck(1'b0, 1'b0);
      tck(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tck(1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 64'(tap_state), 64'hF);
      chk("arst_data", cap_data, 64'd0);
      chk("arst_len", 64'(cap_len), 64'd0);
      chk("arst_fc", 64'(frame_cnt), 64'd0);
      chk("arst_flags", {60'd0, cap_valid, cap_is_ir, cap_ovf, cap_match}, 64'd0);
      #2 rst_n = 1'b1;
      exp_fc = 0;
      tck(1'b0, 1'b0);
      bits = {$urandom, $urandom, $urandom, $urandom};
      scan(1'b0, 12, 0, bits, capvec(bits, 12), '1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
